// File: rtl/ram_rd_if.sv
// Load-request and IO65 device signals of the ram_rd read unit.
// master = requester/device side, slave = ram_rd.
interface ram_rd_if;
    logic        RD_REQ;
    logic [7:0]  RD_ADDR;
    logic [15:0] RAM_0;
    logic [15:0] RAM_1;
    logic [15:0] RAM_2;
    logic [15:0] RAM_3;
    logic [15:0] RAM_4;
    logic [15:0] RAM_5;
    logic [15:0] RAM_6;
    logic [15:0] RAM_7;
    logic [15:0] IO64_OUT;
    logic [15:0] IO65_IN;
    logic        IO65_VALID;
    logic        IO65_ACK;
    logic [15:0] RD_DATA;
    logic        RD_ACK;
    logic        RD_ERR;

    modport master (
        output RD_REQ, RD_ADDR,
        output RAM_0, RAM_1, RAM_2, RAM_3, RAM_4, RAM_5, RAM_6, RAM_7,
        output IO64_OUT, IO65_IN, IO65_VALID,
        input  IO65_ACK, RD_DATA, RD_ACK, RD_ERR
    );

    modport slave (
        input  RD_REQ, RD_ADDR,
        input  RAM_0, RAM_1, RAM_2, RAM_3, RAM_4, RAM_5, RAM_6, RAM_7,
        input  IO64_OUT, IO65_IN, IO65_VALID,
        output IO65_ACK, RD_DATA, RD_ACK, RD_ERR
    );
endinterface

// File: rtl/ram_rd.sv
// Read-side RAM/IO unit: serves loads from RAM_0..7, IO64 and the IO65 handshake port.
// Optional IO_WAIT timeout is enabled by defining RAM_RD_TIMEOUT_EN.
module ram_rd #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic    CLK,
    input  logic    RESET_N,
    ram_rd_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACK     = 2'd1;
    localparam logic [1:0] ST_IO_WAIT = 2'd2;
    localparam logic [1:0] ST_IO_REL  = 2'd3;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  sync_q;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_ack_q, rd_ack_d;
    logic        rd_err_q, rd_err_d;
    logic        io65_ack_q, io65_ack_d;
    logic [15:0] ram_word;
    logic        vs;

    // sync_q[1] is the metastability-safe copy of IO65_VALID
    assign vs = sync_q[1];

    always_comb begin
        ram_word = 16'h0000;
        case (bus.RD_ADDR[2:0])
            3'd0: ram_word = bus.RAM_0;
            3'd1: ram_word = bus.RAM_1;
            3'd2: ram_word = bus.RAM_2;
            3'd3: ram_word = bus.RAM_3;
            3'd4: ram_word = bus.RAM_4;
            3'd5: ram_word = bus.RAM_5;
            3'd6: ram_word = bus.RAM_6;
            default: ram_word = bus.RAM_7;
        endcase
    end

`ifdef RAM_RD_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TO_LAST;
`endif

    always_comb begin
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        rd_ack_d   = 1'b0;
        rd_err_d   = 1'b0;
        io65_ack_d = io65_ack_q;
`ifdef RAM_RD_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.RD_REQ) begin
                    if (bus.RD_ADDR[7:3] == 5'd0) begin
                        rd_data_d = ram_word;
                        rd_ack_d  = 1'b1;
                        state_d   = ST_ACK;
                    end else if (bus.RD_ADDR == 8'h40) begin
                        rd_data_d = bus.IO64_OUT;
                        rd_ack_d  = 1'b1;
                        state_d   = ST_ACK;
                    end else if (bus.RD_ADDR == 8'h41) begin
`ifdef RAM_RD_TIMEOUT_EN
                        cnt_d     = 16'h0000;
`endif
                        state_d   = ST_IO_WAIT;
                    end else begin
                        rd_data_d = 16'h0000;
                        rd_ack_d  = 1'b1;
                        rd_err_d  = 1'b1;
                        state_d   = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            ST_IO_WAIT: begin
                // valid data takes priority over an expiring timeout
                if (vs) begin
                    rd_data_d  = bus.IO65_IN;
                    rd_ack_d   = 1'b1;
                    io65_ack_d = 1'b1;
                    state_d    = ST_IO_REL;
`ifdef RAM_RD_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    rd_data_d = 16'hFFFF;
                    rd_ack_d  = 1'b1;
                    rd_err_d  = 1'b1;
                    state_d   = ST_ACK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            default: begin
                if (!vs) begin
                    io65_ack_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            sync_q     <= 2'b00;
            rd_data_q  <= 16'h0000;
            rd_ack_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            io65_ack_q <= 1'b0;
`ifdef RAM_RD_TIMEOUT_EN
            cnt_q      <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], bus.IO65_VALID};
            rd_data_q  <= rd_data_d;
            rd_ack_q   <= rd_ack_d;
            rd_err_q   <= rd_err_d;
            io65_ack_q <= io65_ack_d;
`ifdef RAM_RD_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.RD_DATA  = rd_data_q;
    assign bus.RD_ACK   = rd_ack_q;
    assign bus.RD_ERR   = rd_err_q;
    assign bus.IO65_ACK = io65_ack_q;

endmodule

// File: tb/tb_ram_rd.sv
// Directed bench for ram_rd: RAM/IO64/unmapped reads, IO65 handshake, reset abort, timeout.
module tb_ram_rd;

    logic CLK;
    logic RESET_N;
    int   n_cmp;
    int   n_err;

    ram_rd_if bus ();

    ram_rd #(.TIMEOUT_CYCLES(8)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request to a non-IO65 address: ack one cycle later, then ack drops, data holds.
    task automatic rd_simple(input string tag, input logic [7:0] addr,
                             input logic [15:0] exp_data, input logic exp_err);
        @(negedge CLK);
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = addr;
        @(negedge CLK);
        chk({tag, "_ack"},  {15'd0, bus.RD_ACK}, 16'd1);
        chk({tag, "_data"}, bus.RD_DATA, exp_data);
        chk({tag, "_err"},  {15'd0, bus.RD_ERR}, {15'd0, exp_err});
        bus.RD_REQ = 1'b0;
        @(negedge CLK);
        chk({tag, "_ack_drop"}, {15'd0, bus.RD_ACK}, 16'd0);
        chk({tag, "_hold"},     bus.RD_DATA, exp_data);
        chk({tag, "_err_drop"}, {15'd0, bus.RD_ERR}, 16'd0);
        $display("read %s addr=%h data=%h err=%0d", tag, addr, exp_data, exp_err);
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        RESET_N        = 1'b0;
        bus.RD_REQ     = 1'b0;
        bus.RD_ADDR    = 8'h00;
        bus.RAM_0      = 16'h1000;
        bus.RAM_1      = 16'h1001;
        bus.RAM_2      = 16'h1002;
        bus.RAM_3      = 16'h1234;
        bus.RAM_4      = 16'h1004;
        bus.RAM_5      = 16'h1005;
        bus.RAM_6      = 16'h1006;
        bus.RAM_7      = 16'h1007;
        bus.IO64_OUT   = 16'hBEEF;
        bus.IO65_IN    = 16'hA5A5;
        bus.IO65_VALID = 1'b0;

        repeat (3) @(negedge CLK);
        chk("rst_data",  bus.RD_DATA, 16'h0000);
        chk("rst_ack",   {15'd0, bus.RD_ACK}, 16'd0);
        chk("rst_err",   {15'd0, bus.RD_ERR}, 16'd0);
        chk("rst_io65",  {15'd0, bus.IO65_ACK}, 16'd0);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("idle_ack",  {15'd0, bus.RD_ACK}, 16'd0);

        rd_simple("ram3",   8'h03, 16'h1234, 1'b0);
        rd_simple("ram0",   8'h00, 16'h1000, 1'b0);
        rd_simple("ram7",   8'h07, 16'h1007, 1'b0);
        rd_simple("io64",   8'h40, 16'hBEEF, 1'b0);
        rd_simple("unm10",  8'h10, 16'h0000, 1'b1);
        rd_simple("unm08",  8'h08, 16'h0000, 1'b1);
        rd_simple("unm3f",  8'h3F, 16'h0000, 1'b1);
        rd_simple("unm42",  8'h42, 16'h0000, 1'b1);
        rd_simple("unmff",  8'hFF, 16'h0000, 1'b1);
        rd_simple("ram5",   8'h05, 16'h1005, 1'b0);

        // Held request: ACK cycle ignores it, IDLE re-accepts it.
        @(negedge CLK);
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 8'h01;
        @(negedge CLK);
        chk("held_ack1", {15'd0, bus.RD_ACK}, 16'd1);
        chk("held_data", bus.RD_DATA, 16'h1001);
        @(negedge CLK);
        chk("held_gap",  {15'd0, bus.RD_ACK}, 16'd0);
        @(negedge CLK);
        chk("held_ack2", {15'd0, bus.RD_ACK}, 16'd1);
        bus.RD_REQ = 1'b0;
        @(negedge CLK);
        chk("held_drop", {15'd0, bus.RD_ACK}, 16'd0);
        $display("read held addr=01 re-accepted");

        // IO65 read, VALID rising 5 cycles after the request.
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 8'h41;
        @(negedge CLK);
        bus.RD_REQ  = 1'b0;
        chk("io65_wait0", {15'd0, bus.RD_ACK}, 16'd0);
        repeat (4) begin
            @(negedge CLK);
            chk("io65_wait", {15'd0, bus.RD_ACK}, 16'd0);
        end
        bus.IO65_VALID = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.RD_ACK !== 1'b1 && n < 8);
        chk("io65_lat_ok", {15'd0, (n >= 2 && n <= 3)}, 16'd1);
        chk("io65_data",  bus.RD_DATA, 16'hA5A5);
        chk("io65_err",   {15'd0, bus.RD_ERR}, 16'd0);
        chk("io65_ackh",  {15'd0, bus.IO65_ACK}, 16'd1);
        // A request during IO_REL must be ignored.
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 8'h02;
        repeat (3) begin
            @(negedge CLK);
            chk("iorel_noack", {15'd0, bus.RD_ACK}, 16'd0);
            chk("iorel_hold",  {15'd0, bus.IO65_ACK}, 16'd1);
        end
        bus.IO65_VALID = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            chk("iorel_noack2", {15'd0, bus.RD_ACK}, 16'd0);
        end while (bus.IO65_ACK !== 1'b0 && n < 8);
        chk("io65_fall_ok", {15'd0, (n >= 1 && n <= 3)}, 16'd1);
        @(negedge CLK);
        chk("after_rel_ack",  {15'd0, bus.RD_ACK}, 16'd1);
        chk("after_rel_data", bus.RD_DATA, 16'h1002);
        bus.RD_REQ = 1'b0;
        @(negedge CLK);
        chk("after_rel_drop", {15'd0, bus.RD_ACK}, 16'd0);
        $display("read io65 addr=41 data=a5a5, follow-up addr=02 data=1002");

        // Reset asserted mid IO_REL.
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 8'h41;
        bus.IO65_IN = 16'h5A5A;
        @(negedge CLK);
        bus.RD_REQ     = 1'b0;
        bus.IO65_VALID = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.RD_ACK !== 1'b1 && n < 8);
        chk("rst2_data_pre", bus.RD_DATA, 16'h5A5A);
        @(negedge CLK);
        chk("rst2_io65_pre", {15'd0, bus.IO65_ACK}, 16'd1);
        #2 RESET_N = 1'b0;
        #1;
        chk("rst2_io65", {15'd0, bus.IO65_ACK}, 16'd0);
        chk("rst2_ack",  {15'd0, bus.RD_ACK}, 16'd0);
        chk("rst2_data", bus.RD_DATA, 16'h0000);
        bus.IO65_VALID = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        $display("reset pulse during IO_REL");
        rd_simple("post_rst_ram2", 8'h02, 16'h1002, 1'b0);

`ifdef RAM_RD_TIMEOUT_EN
        // Timeout: ack at the 8th IO_WAIT cycle, IO65_ACK never asserts.
        @(negedge CLK);
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 8'h41;
        n = 0;
        do begin
            @(negedge CLK);
            bus.RD_REQ = 1'b0;
            n++;
            chk("to_io65_low", {15'd0, bus.IO65_ACK}, 16'd0);
        end while (bus.RD_ACK !== 1'b1 && n < 20);
        chk("to_cycles", n[15:0], 16'd9);
        chk("to_data",   bus.RD_DATA, 16'hFFFF);
        chk("to_err",    {15'd0, bus.RD_ERR}, 16'd1);
        @(negedge CLK);
        chk("to_drop",   {15'd0, bus.RD_ACK}, 16'd0);
        chk("to_errdrop", {15'd0, bus.RD_ERR}, 16'd0);
        $display("read io65 timeout data=ffff err=1 after %0d cycles", n);
`else
        // Without timeout IO_WAIT waits until the device answers.
        @(negedge CLK);
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 8'h41;
        bus.IO65_IN = 16'h0F0F;
        @(negedge CLK);
        bus.RD_REQ = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            chk("nto_wait", {15'd0, bus.RD_ACK}, 16'd0);
        end
        bus.IO65_VALID = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.RD_ACK !== 1'b1 && n < 8);
        chk("nto_data", bus.RD_DATA, 16'h0F0F);
        chk("nto_err",  {15'd0, bus.RD_ERR}, 16'd0);
        bus.IO65_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        chk("nto_rel", {15'd0, bus.IO65_ACK}, 16'd0);
        $display("read io65 long wait data=0f0f");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
